// File: rtl/tmcpu_pkg.sv
// Shared core definitions: sequencer states and PC geometry.
package tmcpu_pkg;

    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    // Instruction fetch requires word alignment.
    function automatic logic pc_misaligned(input logic [PC_W-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: picks the PC the register loads at the next edge and
// decides whether the redirect buffer is written or cleared this cycle.
// TMCPU_PC_ALIGN_CHECK_EN: misaligned redirect targets become traps instead
// of having their low bits dropped.
module pc_next_sel
    import tmcpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [PC_W-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  pc_state_e         state_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              stall_i,
    input  logic              halt_i,
    input  logic              trap_i,
    input  logic              redirect_valid_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    input  logic              pend_valid_i,
    input  logic [PC_W-1:0]   pend_pc_i,
    output logic [PC_W-1:0]   next_pc_o,
    output logic              buf_wr_o,
    output logic              buf_clr_o,
    output logic              misalign_o
);

    logic [PC_W-1:0] tgt;
    logic            use_tgt;

`ifndef TMCPU_PC_ALIGN_CHECK_EN
    // Low target bits are discarded when alignment is not enforced.
    logic [1:0] unused_tgt_lo;
    assign unused_tgt_lo = tgt[1:0];
`endif

    // Fixed-priority selection: trap, stall/halt hold, live redirect,
    // buffered redirect, then sequential step.
    always_comb begin
        next_pc_o  = pc_i;
        buf_wr_o   = 1'b0;
        buf_clr_o  = 1'b0;
        misalign_o = 1'b0;
        tgt        = '0;
        use_tgt    = 1'b0;
        unique case (state_i)
            ST_BOOT: next_pc_o = RESET_VECTOR;
            ST_RUN: begin
                if (trap_i) begin
                    next_pc_o = TRAP_VECTOR;
                    buf_clr_o = 1'b1;
                end else if (stall_i || halt_i) begin
                    // Hold; a redirect arriving now is parked, newest wins.
                    buf_wr_o = redirect_valid_i;
                end else if (redirect_valid_i) begin
                    tgt       = redirect_pc_i;
                    use_tgt   = 1'b1;
                    buf_clr_o = 1'b1;
                end else if (pend_valid_i) begin
                    tgt       = pend_pc_i;
                    use_tgt   = 1'b1;
                    buf_clr_o = 1'b1;
                end else begin
                    next_pc_o = pc_i + PC_STEP;
                end
            end
            ST_HALT: begin
                if (trap_i) begin
                    next_pc_o = TRAP_VECTOR;
                    buf_clr_o = 1'b1;
                end
            end
            default: next_pc_o = RESET_VECTOR;
        endcase

        if (use_tgt) begin
`ifdef TMCPU_PC_ALIGN_CHECK_EN
            if (pc_misaligned(tgt)) begin
                next_pc_o  = TRAP_VECTOR;
                misalign_o = 1'b1;
            end else begin
                next_pc_o = tgt;
            end
`else
            next_pc_o = {tgt[PC_W-1:2], 2'b00};
`endif
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the single-cycle core: boot window, run/halt
// control, one-entry redirect buffer for redirects that land during a stall.
// TMCPU_PC_ALIGN_CHECK_EN: enables misaligned-redirect trapping in pc_next_sel.
module pc_sequencer
    import tmcpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [PC_W-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              BOOT_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              redirect_valid_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    input  logic              trap_i,
    input  logic              halt_i,
    input  logic              resume_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [PC_W-1:0]   next_pc_o,
    output logic              pc_valid_o,
    output logic              halted_o,
    output logic              redirect_pend_o,
    output logic              misalign_o
);

    localparam int BCW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BCW-1:0] BOOT_INIT = BCW'(BOOT_CYCLES - 1);

    pc_state_e       state_q, state_d;
    logic [BCW-1:0]  boot_cnt_q;
    logic            pend_vld_q;
    logic [PC_W-1:0] pend_pc_q;
    logic            buf_wr, buf_clr;

    pc_next_sel #(
        .RESET_VECTOR (RESET_VECTOR),
        .TRAP_VECTOR  (TRAP_VECTOR)
    ) u_sel (
        .state_i          (state_q),
        .pc_i             (pc_o),
        .stall_i          (stall_i),
        .halt_i           (halt_i),
        .trap_i           (trap_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .pend_valid_i     (pend_vld_q),
        .pend_pc_i        (pend_pc_q),
        .next_pc_o        (next_pc_o),
        .buf_wr_o         (buf_wr),
        .buf_clr_o        (buf_clr),
        .misalign_o       (misalign_o)
    );

    // State transitions; trap always lands in RUN and outranks halt/resume.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: if (boot_cnt_q == '0) state_d = ST_RUN;
            ST_RUN:  if (!trap_i && halt_i) state_d = ST_HALT;
            ST_HALT: if (trap_i || resume_i) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // State register and boot down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= BOOT_INIT;
        end else begin
            state_q <= state_d;
            if (state_q == ST_BOOT && boot_cnt_q != '0)
                boot_cnt_q <= boot_cnt_q - BCW'(1);
        end
    end

    // PC register follows the mux unconditionally; holds are encoded there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_o <= RESET_VECTOR;
        else        pc_o <= next_pc_o;
    end

    // One-entry redirect buffer; clear and write are mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
            pend_pc_q  <= '0;
        end else if (buf_clr) begin
            pend_vld_q <= 1'b0;
        end else if (buf_wr) begin
            pend_vld_q <= 1'b1;
            pend_pc_q  <= redirect_pc_i;
        end
    end

    assign pc_valid_o      = (state_q == ST_RUN) && !stall_i;
    assign halted_o        = (state_q == ST_HALT);
    assign redirect_pend_o = pend_vld_q;

endmodule
